// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the boot-ROM arbiter: FSM states, requester
// IDs, wait-counter width and the round-robin arbitration helper.
package rom_arb_pkg;

    localparam int CNT_W = 3;

    // Requester IDs; the ID value doubles as the gnt_scsi mux select.
    localparam logic HOST = 1'b0;
    localparam logic SCSI = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_ACK     = 3'd3,
        ST_RECOVER = 3'd4
    } arb_state_t;

    // Returns the requester ID that wins this IDLE sample.
    function automatic logic pick_winner(
        input logic req_host,
        input logic req_scsi,
        input logic prefer_scsi
    );
        if (req_host && req_scsi) begin
            return prefer_scsi ? SCSI : HOST;
        end
        return req_scsi ? SCSI : HOST;
    endfunction

endpackage

// File: rtl/rom_wait_counter.sv
// Load / decrement counter timing the STROBE phase; flags zero and last count.
module rom_wait_counter
    import rom_arb_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero,
    output logic             o_last
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);
    assign o_last = (r_count == CNT_W'(1));

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing the boot ROM between the Zorro host and SCSI side.
// Define ROM_ARBITER_WRITE_EN to let write cycles pulse ROM_WE_n (flash programming).
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
)(
    input  logic CLK,
    input  logic RESET_n,
    input  logic shutup,
    input  logic host_req,
    input  logic host_rw,
    input  logic scsi_req,
    input  logic scsi_rw,
    output logic host_ack,
    output logic scsi_ack,
    output logic gnt_scsi,
    output logic busy,
    output logic ROM_CE_n,
    output logic ROM_OE_n,
    output logic ROM_WE_n
);

    // Out-of-range settings are clamped to the legal 1..7 window.
    localparam int unsigned WAIT_EFF = (WAIT_CYCLES < 1) ? 1 :
                                       (WAIT_CYCLES > 7) ? 7 : WAIT_CYCLES;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_EFF);

    arb_state_t r_state;
    logic       r_rw;
    logic       r_prefer_scsi;
    logic       r_gnt_scsi;
    logic       r_host_ack;
    logic       r_scsi_ack;
    logic       r_busy;
    logic       r_ce_n;
    logic       r_oe_n;
    logic       r_we_n;

    logic       w_owner_req;
    logic       w_win_id;
    logic       w_win_rw;
    logic       w_any_req;
    logic       w_strobe_oe_n;
    logic       w_strobe_we_n;
    logic       w_cnt_load;
    logic       w_cnt_dec;
    logic       w_cnt_zero;
    logic       w_cnt_last;

    assign w_owner_req   = (r_gnt_scsi == SCSI) ? scsi_req : host_req;
    assign w_any_req     = host_req | scsi_req;
    assign w_win_id      = pick_winner(host_req, scsi_req, r_prefer_scsi);
    assign w_win_rw      = (w_win_id == SCSI) ? scsi_rw : host_rw;
    assign w_strobe_oe_n = ~r_rw;

`ifdef ROM_ARBITER_WRITE_EN
    assign w_strobe_we_n = r_rw;
`else
    // Writes still run full timing and get acked, but never reach the ROM.
    assign w_strobe_we_n = 1'b1;
`endif

    assign w_cnt_load = (r_state == ST_SETUP);
    assign w_cnt_dec  = (r_state == ST_STROBE);

    rom_wait_counter u_wait_counter (
        .CLK        (CLK),
        .RESET_n    (RESET_n),
        .i_load     (w_cnt_load),
        .i_load_val (WAIT_LOAD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero),
        .o_last     (w_cnt_last)
    );

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state       <= ST_IDLE;
            r_rw          <= 1'b1;
            r_prefer_scsi <= 1'b0;
            r_gnt_scsi    <= HOST;
            r_host_ack    <= 1'b0;
            r_scsi_ack    <= 1'b0;
            r_busy        <= 1'b0;
            r_ce_n        <= 1'b1;
            r_oe_n        <= 1'b1;
            r_we_n        <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!shutup && w_any_req) begin
                        r_state       <= ST_SETUP;
                        r_gnt_scsi    <= w_win_id;
                        r_rw          <= w_win_rw;
                        r_prefer_scsi <= (w_win_id == HOST);
                        r_busy        <= 1'b1;
                        r_ce_n        <= 1'b0;
                        r_oe_n        <= 1'b1;
                        r_we_n        <= 1'b1;
                    end
                end

                ST_SETUP: begin
                    if (!w_owner_req) begin
                        r_state <= ST_RECOVER;
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                    end else begin
                        r_state <= ST_STROBE;
                        r_oe_n  <= w_strobe_oe_n;
                        r_we_n  <= w_strobe_we_n;
                    end
                end

                ST_STROBE: begin
                    // An abort wins over the final strobe cycle: no ack is issued.
                    if (!w_owner_req) begin
                        r_state <= ST_RECOVER;
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                    end else if (w_cnt_last || w_cnt_zero) begin
                        r_state    <= ST_ACK;
                        r_host_ack <= (r_gnt_scsi == HOST);
                        r_scsi_ack <= (r_gnt_scsi == SCSI);
                    end
                end

                ST_ACK: begin
                    if (!w_owner_req) begin
                        r_state    <= ST_RECOVER;
                        r_host_ack <= 1'b0;
                        r_scsi_ack <= 1'b0;
                        r_ce_n     <= 1'b1;
                        r_oe_n     <= 1'b1;
                        r_we_n     <= 1'b1;
                    end
                end

                ST_RECOVER: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_host_ack <= 1'b0;
                    r_scsi_ack <= 1'b0;
                    r_busy     <= 1'b0;
                    r_ce_n     <= 1'b1;
                    r_oe_n     <= 1'b1;
                    r_we_n     <= 1'b1;
                end
            endcase
        end
    end

    assign host_ack = r_host_ack;
    assign scsi_ack = r_scsi_ack;
    assign gnt_scsi = r_gnt_scsi;
    assign busy     = r_busy;
    assign ROM_CE_n = r_ce_n;
    assign ROM_OE_n = r_oe_n;
    assign ROM_WE_n = r_we_n;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed vector table, hand-written corner sequences,
// then random requester traffic checked against a time-based reference model.
module tb_rom_arbiter;

    localparam int W = 2;

`ifdef ROM_ARBITER_WRITE_EN
    localparam logic WR_WE = 1'b0;
`else
    localparam logic WR_WE = 1'b1;
`endif

    logic CLK = 1'b0;
    logic RESET_n = 1'b0;
    logic shutup = 1'b0;
    logic host_req = 1'b0;
    logic host_rw = 1'b0;
    logic scsi_req = 1'b0;
    logic scsi_rw = 1'b0;
    logic host_ack, scsi_ack, gnt_scsi, busy, ROM_CE_n, ROM_OE_n, ROM_WE_n;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    rom_arbiter #(.WAIT_CYCLES(W)) dut (
        .CLK      (CLK),
        .RESET_n  (RESET_n),
        .shutup   (shutup),
        .host_req (host_req),
        .host_rw  (host_rw),
        .scsi_req (scsi_req),
        .scsi_rw  (scsi_rw),
        .host_ack (host_ack),
        .scsi_ack (scsi_ack),
        .gnt_scsi (gnt_scsi),
        .busy     (busy),
        .ROM_CE_n (ROM_CE_n),
        .ROM_OE_n (ROM_OE_n),
        .ROM_WE_n (ROM_WE_n)
    );

    // Output vector order: {CE_n, OE_n, WE_n, host_ack, scsi_ack, gnt_scsi, busy}
    typedef struct {
        logic       rst;
        logic       sh;
        logic       hr;
        logic       hrw;
        logic       sr;
        logic       srw;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [6:0] outs();
        return {ROM_CE_n, ROM_OE_n, ROM_WE_n, host_ack, scsi_ack, gnt_scsi, busy};
    endfunction

    function automatic vec_t mk(input logic rst, input logic sh, input logic hr,
                                input logic hrw, input logic sr, input logic srw,
                                input logic [6:0] e);
        vec_t v;
        v.rst = rst; v.sh = sh; v.hr = hr; v.hrw = hrw; v.sr = sr; v.srw = srw; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (ce oe we hack sack gnt busy)", name, act, exp);
        end else begin
            $display("ok   %s: %b", name, act);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then sample after the rising edge.
    task automatic cyc(input logic sh, input logic hr, input logic hrw,
                       input logic sr, input logic srw);
        @(negedge CLK);
        shutup = sh; host_req = hr; host_rw = hrw; scsi_req = sr; scsi_rw = srw;
        @(posedge CLK);
        #1;
    endtask

    // Reference model: tracks elapsed cycles since grant rather than FSM states.
    bit m_active, m_recover, m_owner_scsi, m_rw, m_prefer_scsi, m_gnt;
    int m_age;

    task automatic model_reset();
        m_active = 0; m_recover = 0; m_owner_scsi = 0; m_rw = 0;
        m_prefer_scsi = 0; m_gnt = 0; m_age = 0;
    endtask

    task automatic model_step(input bit sh, input bit hr, input bit hrw,
                              input bit sr, input bit srw);
        bit own_req;
        bit ws;
        if (m_recover) begin
            m_recover = 0;
        end else if (m_active) begin
            own_req = m_owner_scsi ? sr : hr;
            if (!own_req) begin
                m_active = 0;
                m_recover = 1;
            end else begin
                m_age++;
            end
        end else if (!sh && (hr || sr)) begin
            ws = (hr && sr) ? m_prefer_scsi : sr;
            m_owner_scsi = ws;
            m_gnt = ws;
            m_prefer_scsi = !ws;
            m_rw = ws ? srw : hrw;
            m_active = 1;
            m_age = 0;
        end
    endtask

    function automatic logic [6:0] model_out();
        logic ce, oe, we, ha, sa, b;
        ce = 1; oe = 1; we = 1; ha = 0; sa = 0; b = 0;
        if (m_recover) begin
            b = 1;
        end else if (m_active) begin
            b = 1;
            ce = 0;
            if (m_age >= 1) begin
                oe = !m_rw;
                we = m_rw ? 1'b1 : WR_WE;
            end
            if (m_age > W) begin
                ha = !m_owner_scsi;
                sa = m_owner_scsi;
            end
        end
        return {ce, oe, we, ha, sa, m_gnt, b};
    endfunction

    initial begin
        // Host read alone
        tbl.push_back(mk(1,0,0,0,0,0, 7'b1110000));
        tbl.push_back(mk(0,0,0,0,0,0, 7'b1110000));
        tbl.push_back(mk(0,0,1,1,0,0, 7'b0110001));
        tbl.push_back(mk(0,0,1,1,0,0, 7'b0010001));
        tbl.push_back(mk(0,0,1,1,0,0, 7'b0010001));
        tbl.push_back(mk(0,0,1,1,0,0, 7'b0011001));
        tbl.push_back(mk(0,0,1,1,0,0, 7'b0011001));
        tbl.push_back(mk(0,0,0,0,0,0, 7'b1110001));
        tbl.push_back(mk(0,0,0,0,0,0, 7'b1110000));
        // Contention right after reset: host first, SCSI after RECOVER
        tbl.push_back(mk(1,0,0,0,0,0, 7'b1110000));
        tbl.push_back(mk(0,0,1,1,1,1, 7'b0110001));
        tbl.push_back(mk(0,0,1,1,1,1, 7'b0010001));
        tbl.push_back(mk(0,0,1,1,1,1, 7'b0010001));
        tbl.push_back(mk(0,0,1,1,1,1, 7'b0011001));
        tbl.push_back(mk(0,0,0,0,1,1, 7'b1110001));
        tbl.push_back(mk(0,0,0,0,1,1, 7'b1110000));
        tbl.push_back(mk(0,0,0,0,1,1, 7'b0110011));
        tbl.push_back(mk(0,0,0,0,1,1, 7'b0010011));
        tbl.push_back(mk(0,0,0,0,1,1, 7'b0010011));
        tbl.push_back(mk(0,0,0,0,1,1, 7'b0010111));
        tbl.push_back(mk(0,0,0,0,0,0, 7'b1110011));
        tbl.push_back(mk(0,0,0,0,0,0, 7'b1110010));
        // shutup blocks grants in IDLE but not a running cycle
        tbl.push_back(mk(0,1,1,1,0,0, 7'b1110010));
        tbl.push_back(mk(0,1,1,1,0,0, 7'b1110010));
        tbl.push_back(mk(0,0,1,1,0,0, 7'b0110001));
        tbl.push_back(mk(0,1,1,1,0,0, 7'b0010001));
        tbl.push_back(mk(0,1,1,1,0,0, 7'b0010001));
        tbl.push_back(mk(0,1,1,1,0,0, 7'b0011001));
        tbl.push_back(mk(0,0,0,0,0,0, 7'b1110001));
        tbl.push_back(mk(0,0,0,0,0,0, 7'b1110000));
        // SCSI write
        tbl.push_back(mk(0,0,0,0,1,0, 7'b0110011));
        tbl.push_back(mk(0,0,0,0,1,0, {2'b01, WR_WE, 4'b0011}));
        tbl.push_back(mk(0,0,0,0,1,0, {2'b01, WR_WE, 4'b0011}));
        tbl.push_back(mk(0,0,0,0,1,0, {2'b01, WR_WE, 4'b0111}));
        tbl.push_back(mk(0,0,0,0,0,0, 7'b1110011));
        tbl.push_back(mk(0,0,0,0,0,0, 7'b1110010));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge CLK);
            RESET_n = !tbl[i].rst;
            shutup = tbl[i].sh; host_req = tbl[i].hr; host_rw = tbl[i].hrw;
            scsi_req = tbl[i].sr; scsi_rw = tbl[i].srw;
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

        // Abort: host drops request during STROBE
        cyc(0,1,1,0,0); check("abort_setup",   outs(), 7'b0110001);
        cyc(0,1,1,0,0); check("abort_strobe",  outs(), 7'b0010001);
        cyc(0,0,1,0,0); check("abort_recover", outs(), 7'b1110001);
        cyc(0,0,1,0,0); check("abort_idle",    outs(), 7'b1110000);
        cyc(0,0,1,0,0); check("abort_noack",   outs(), 7'b1110000);

        // Reset pulsed during ACK; host granted last so SCSI would otherwise be preferred
        cyc(0,1,1,0,0); check("rst_setup", outs(), 7'b0110001);
        cyc(0,1,1,0,0);
        cyc(0,1,1,0,0);
        cyc(0,1,1,0,0); check("rst_ack", outs(), 7'b0011001);
        #2;
        RESET_n = 1'b0;
        #1;
        check("rst_async", outs(), 7'b1110000);
        @(negedge CLK);
        host_req = 1'b0;
        @(negedge CLK);
        RESET_n = 1'b1;
        @(posedge CLK);
        #1;
        check("rst_idle", outs(), 7'b1110000);
        cyc(0,1,1,1,1); check("rst_pref_host", outs(), 7'b0110001);
        cyc(0,0,1,0,1); check("rst_abort_both", outs(), 7'b1110001);
        cyc(0,0,1,0,1); check("rst_back_idle", outs(), 7'b1110000);

        // Random traffic against the reference model
        @(negedge CLK);
        RESET_n = 1'b0;
        shutup = 0; host_req = 0; scsi_req = 0;
        @(negedge CLK);
        RESET_n = 1'b1;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge CLK);
            if (!host_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    host_req = 1'b1;
                    host_rw = 1'($urandom_range(0, 1));
                end
            end else if (host_ack) begin
                if ($urandom_range(0, 1) == 0) host_req = 1'b0;
            end else if ($urandom_range(0, 29) == 0) begin
                host_req = 1'b0;
            end
            if (!scsi_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    scsi_req = 1'b1;
                    scsi_rw = 1'($urandom_range(0, 1));
                end
            end else if (scsi_ack) begin
                if ($urandom_range(0, 1) == 0) scsi_req = 1'b0;
            end else if ($urandom_range(0, 29) == 0) begin
                scsi_req = 1'b0;
            end
            shutup = ($urandom_range(0, 7) == 0);
            @(posedge CLK);
            model_step(shutup, host_req, host_rw, scsi_req, scsi_rw);
            #1;
            check($sformatf("rand%0d", n), outs(), model_out());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, number of cycles the strobe phase lasts (legal 1..7).
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RESET_n  input  1  reset, asynchronous, active-low.
REQ-004 shutup  input  1  autoconfig shut-up; blocks new grants while high.
REQ-005 host_req  input  1  Zorro host requests a ROM cycle; held until host_ack seen.
REQ-006 host_rw  input  1  host direction, 1=read, 0=write.
REQ-007 scsi_req  input  1  SCSI-side requester requests a ROM cycle; held until scsi_ack seen.
REQ-008 scsi_rw  input  1  SCSI direction, 1=read, 0=write.
REQ-009 host_ack / scsi_ack  output  1 each  cycle-complete acknowledge to the granted requester.
REQ-010 gnt_scsi  output  1  address/data mux select; 1=SCSI owns the ROM bus.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 ROM_CE_n, ROM_OE_n, ROM_WE_n  output  1 each  active-low ROM strobes, registered.

Function
REQ-013 FSM states: IDLE, SETUP, STROBE, ACK, RECOVER.
REQ-014 IDLE: shutup=0 and any req sampled -> grant, latch rw of winner, go SETUP; otherwise stay.
REQ-015 Arbitration: single request wins; both requests -> winner is the requester not granted last (round-robin); after reset host is preferred first.
REQ-016 gnt_scsi updates only on the IDLE->SETUP edge and holds through RECOVER.
REQ-017 SETUP: exactly 1 cycle, CE_n=0, OE_n=WE_n=1; load wait counter with WAIT_CYCLES; go STROBE.
REQ-018 STROBE: CE_n=0, OE_n=0 if read, WE_n=0 if write; lasts exactly WAIT_CYCLES cycles, then ACK.
REQ-019 ACK: strobes held as in STROBE; ack of granted requester =1; stay until its req deasserts, then RECOVER.
REQ-020 Latency: req sampled at edge k -> ack high after edge k+1+WAIT_CYCLES (WAIT_CYCLES=2: 3 clocks).
REQ-021 Abort: granted req drops in SETUP or STROBE -> RECOVER next edge, no ack issued.
REQ-022 RECOVER: exactly 1 cycle, all strobes high, acks low; go IDLE; no back-to-back cycle without RECOVER.
REQ-023 shutup rising mid-cycle does not abort the current cycle; only blocks the next grant.
REQ-024 Request from non-granted requester is held pending, never dropped; served after RECOVER.
REQ-025 At most one ack high at any time; ack never high outside ACK.

Reset
REQ-026 RESET_n low forces IDLE, acks=0, gnt_scsi=0, busy=0, all ROM strobes=1, counter=0, round-robin pointer=host-preferred.
REQ-027 Reset mid-cycle deasserts all strobes asynchronously; no ack after release until a fresh request.

Configuration
REQ-028 Macro ROM_ARBITER_WRITE_EN defined: write cycles drive ROM_WE_n low in STROBE/ACK (flash programming).
REQ-029 Macro absent: write cycles run full timing and are acked, but ROM_WE_n stays 1 and ROM_OE_n stays 1 (write discarded).

Structure
REQ-030 Package rom_arb_pkg holds FSM state enum, requester ID constants (HOST=0, SCSI=1), counter width constant (3).
REQ-031 One sub-module, rom_wait_counter: load/decrement/zero-flag counter used by STROBE.

Verification
REQ-032 Host read alone, WAIT_CYCLES=2 -> CE_n low 1 cycle before OE_n, host_ack high 3 clocks after req sampled, WE_n stays 1.
REQ-033 host_req and scsi_req same edge after reset -> host granted first, SCSI served after 1-cycle RECOVER, gnt_scsi=1 only during SCSI cycle.
REQ-034 Scsi write with ROM_ARBITER_WRITE_EN -> WE_n low for STROBE+ACK; rebuild without macro -> WE_n never low, scsi_ack still asserted.
REQ-035 host_req drops during STROBE -> RECOVER next edge, host_ack never asserted, strobes high.
REQ-036 shutup=1 with host_req high in IDLE -> no grant, busy=0; shutup asserted during STROBE -> cycle completes with ack.
REQ-037 RESET_n pulsed low during ACK -> strobes and ack go high/low immediately, FSM IDLE, host preferred on next contention.
